// File: rtl/snake_field_reader.sv
// snake_field_reader: snapshots a packed snake-game field on request and streams
// every cell out in raster order over a valid/ready interface, with decoded colour
// and frame-position flags. Optional frame statistics (snake length, first apple
// position) are built when the macro SNAKE_FIELD_STATS_EN is defined; otherwise the
// statistics ports are tied to zero.
module snake_field_reader #(
    parameter int SIZE_X     = 10,
    parameter int SIZE_Y     = 10,
    parameter int FIELD_SIZE = SIZE_X * SIZE_Y * 3,
    localparam int XBITS     = (SIZE_X > 1) ? $clog2(SIZE_X) : 1,
    localparam int YBITS     = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1,
    localparam int LBITS     = $clog2(SIZE_X * SIZE_Y + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIELD_SIZE-1:0] field,
    input  logic                  frame_req,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XBITS-1:0]      out_x,
    output logic [YBITS-1:0]      out_y,
    output logic [2:0]            out_code,
    output logic [11:0]           out_rgb,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  out_err,
    output logic                  frame_done,
    output logic [LBITS-1:0]      snake_len,
    output logic                  apple_valid,
    output logic [XBITS-1:0]      apple_x,
    output logic [YBITS-1:0]      apple_y
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                state_q, state_d;
    logic [FIELD_SIZE-1:0] snap_q;
    logic [XBITS-1:0]      x_q;
    logic [YBITS-1:0]      y_q;

    logic        scan;
    logic        start;
    logic        fire;
    logic        x_last;
    logic        y_last;
    logic        last_beat;
    logic [31:0] cell_idx;
    logic [2:0]  code_raw;
    logic [11:0] rgb_raw;

    assign scan      = (state_q == StScan);
    assign start     = (state_q == StIdle) && frame_req;
    assign fire      = scan && out_ready;
    assign x_last    = (x_q == XBITS'(SIZE_X - 1));
    assign y_last    = (y_q == YBITS'(SIZE_Y - 1));
    assign last_beat = x_last && y_last;
    assign cell_idx  = 32'(y_q) * 32'(SIZE_X) + 32'(x_q);
    assign code_raw  = 3'(snap_q >> (3 * cell_idx));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; frame_req only matters in idle, so requests are never queued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (frame_req) state_d = StScan;
            StScan: if (fire && last_beat) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Snapshot capture and raster cursor; beats always read the snapshot, never field.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (start) begin
            snap_q <= field;
            x_q    <= '0;
            y_q    <= '0;
        end else if (fire) begin
            if (x_last) begin
                x_q <= '0;
                y_q <= y_last ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    // Colour decode: snake green, apple red, illegal codes magenta.
    always_comb begin
        rgb_raw = 12'h000;
        case (code_raw)
            3'd0:                   rgb_raw = 12'h000;
            3'd1, 3'd2, 3'd3, 3'd4: rgb_raw = 12'h0F0;
            3'd5:                   rgb_raw = 12'hF00;
            default:                rgb_raw = 12'hF0F;
        endcase
    end

    // Beat outputs are forced to zero outside a scan so reset/idle present a clean bus.
    always_comb begin
        out_valid  = scan;
        out_x      = x_q;
        out_y      = y_q;
        out_code   = scan ? code_raw : 3'd0;
        out_rgb    = scan ? rgb_raw : 12'h000;
        out_sof    = scan && (x_q == '0) && (y_q == '0);
        out_eol    = scan && x_last;
        out_eof    = scan && last_beat;
        out_err    = scan && (code_raw[2:1] == 2'b11);
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
    end

`ifdef SNAKE_FIELD_STATS_EN
    logic [LBITS-1:0] len_acc_q, len_nxt, snake_len_q;
    logic             found_q, found_nxt, apple_valid_q;
    logic [XBITS-1:0] ax_acc_q, ax_nxt, apple_x_q;
    logic [YBITS-1:0] ay_acc_q, ay_nxt, apple_y_q;
    logic             is_snake;
    logic             apple_hit;

    // Accumulator next values including the beat currently being accepted.
    always_comb begin
        is_snake  = (code_raw >= 3'd1) && (code_raw <= 3'd4);
        apple_hit = (code_raw == 3'd5) && !found_q;
        len_nxt   = len_acc_q + LBITS'(is_snake);
        found_nxt = found_q | apple_hit;
        ax_nxt    = apple_hit ? x_q : ax_acc_q;
        ay_nxt    = apple_hit ? y_q : ay_acc_q;
    end

    // Accumulate over accepted beats; publish all statistics together on entry to done.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_acc_q     <= '0;
            found_q       <= 1'b0;
            ax_acc_q      <= '0;
            ay_acc_q      <= '0;
            snake_len_q   <= '0;
            apple_valid_q <= 1'b0;
            apple_x_q     <= '0;
            apple_y_q     <= '0;
        end else if (start) begin
            len_acc_q <= '0;
            found_q   <= 1'b0;
            ax_acc_q  <= '0;
            ay_acc_q  <= '0;
        end else if (fire) begin
            len_acc_q <= len_nxt;
            found_q   <= found_nxt;
            ax_acc_q  <= ax_nxt;
            ay_acc_q  <= ay_nxt;
            if (last_beat) begin
                snake_len_q   <= len_nxt;
                apple_valid_q <= found_nxt;
                apple_x_q     <= ax_nxt;
                apple_y_q     <= ay_nxt;
            end
        end
    end

    assign snake_len   = snake_len_q;
    assign apple_valid = apple_valid_q;
    assign apple_x     = apple_x_q;
    assign apple_y     = apple_y_q;
`else
    assign snake_len   = '0;
    assign apple_valid = 1'b0;
    assign apple_x     = '0;
    assign apple_y     = '0;
`endif

endmodule

// File: tb/tb_snake_field_reader.sv
// Directed bench for snake_field_reader on the default 10x10 field.
module tb_snake_field_reader;
    localparam int SX = 10;
    localparam int SY = 10;
    localparam int FS = SX * SY * 3;
`ifdef SNAKE_FIELD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, frame_req, out_ready;
    logic [FS-1:0] field, fmodel;
    logic          busy, out_valid, out_sof, out_eol, out_eof, out_err, frame_done;
    logic [3:0]    out_x, out_y, apple_x, apple_y;
    logic [2:0]    out_code;
    logic [11:0]   out_rgb;
    logic [6:0]    snake_len;
    logic          apple_valid;

    always #5 clk = ~clk;

    snake_field_reader dut (
        .clk(clk), .rst(rst), .field(field), .frame_req(frame_req), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_code(out_code), .out_rgb(out_rgb), .out_sof(out_sof), .out_eol(out_eol),
        .out_eof(out_eof), .out_err(out_err), .frame_done(frame_done),
        .snake_len(snake_len), .apple_valid(apple_valid), .apple_x(apple_x),
        .apple_y(apple_y)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input logic [2:0] c);
        case (c)
            3'd0:                   return 12'h000;
            3'd1, 3'd2, 3'd3, 3'd4: return 12'h0F0;
            3'd5:                   return 12'hF00;
            default:                return 12'hF0F;
        endcase
    endfunction

    task set_cell(input int x, input int y, input logic [2:0] c);
        fmodel[3*(y*SX+x) +: 3] = c;
    endtask

    logic [2:0]  rec_code [100];
    logic [11:0] rec_rgb  [100];
    logic [3:0]  rec_x    [100];
    logic [3:0]  rec_y    [100];
    logic        rec_sof  [100];
    logic        rec_eof  [100];
    logic        rec_err  [100];
    int          beats, mism, stall_err, early_fd;
    bit          done_seen, fd_ok;
    logic [6:0]  st_len;
    logic        st_av;
    logic [3:0]  st_ax, st_ay;

    // Requests one frame of fmodel and collects beats until the done cycle (bounded).
    // mode 0: out_ready always 1; mode 1: out_ready follows 1,0,0,1 per cycle.
    task automatic run_frame(input int mode, input bit clear_after, input bit keep_req);
        int         cyc;
        bit         eof_taken, prev_stall;
        logic [26:0] cur, prev_sig;
        logic [2:0] ec;
        @(posedge clk); #1;
        field = fmodel;
        frame_req = 1'b1;
        out_ready = 1'b0;
        beats = 0; mism = 0; stall_err = 0; early_fd = 0;
        done_seen = 0; fd_ok = 0; prev_stall = 0; eof_taken = 0; prev_sig = '0;
        @(posedge clk); #1;
        if (!keep_req) frame_req = 1'b0;
        if (clear_after) field = '0;
        cyc = 0;
        while (!done_seen && cyc < 1000) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            @(negedge clk);
            if (eof_taken) begin
                done_seen = 1;
                fd_ok  = frame_done && !out_valid && busy;
                st_len = snake_len; st_av = apple_valid; st_ax = apple_x; st_ay = apple_y;
            end else begin
                if (frame_done) early_fd++;
                if (out_valid) begin
                    cur = {out_x, out_y, out_code, out_rgb, out_sof, out_eol, out_eof, out_err};
                    if (prev_stall && cur !== prev_sig) stall_err++;
                    prev_sig   = cur;
                    prev_stall = !out_ready;
                    if (out_ready) begin
                        if (beats < 100) begin
                            rec_code[beats] = out_code; rec_rgb[beats] = out_rgb;
                            rec_x[beats] = out_x; rec_y[beats] = out_y;
                            rec_sof[beats] = out_sof; rec_eof[beats] = out_eof;
                            rec_err[beats] = out_err;
                            ec = fmodel[3*beats +: 3];
                            if (out_x !== 4'(beats % SX) || out_y !== 4'(beats / SX) ||
                                out_code !== ec || out_rgb !== exp_rgb(ec) ||
                                out_sof !== (beats == 0) || out_eol !== (beats % SX == SX - 1) ||
                                out_eof !== (beats == SX * SY - 1) || out_err !== (ec >= 3'd6))
                                mism++;
                        end
                        beats++;
                        if (out_eof) eof_taken = 1;
                    end
                end else begin
                    prev_stall = 0;
                end
            end
            if (!done_seen) begin
                @(posedge clk); #1;
            end
            cyc++;
        end
    endtask

    int cnt, cyc, vcnt, fcnt;

    initial begin
        rst = 1'b1; frame_req = 1'b0; out_ready = 1'b0; field = '0; fmodel = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_code_rgb", {out_code, out_rgb}, 0);
        check_eq("rst_flags", {out_sof, out_eol, out_eof, out_err}, 0);
        check_eq("rst_xy", {out_x, out_y}, 0);
        check_eq("rst_stats", {snake_len, apple_valid, apple_x, apple_y}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame A: apple at (0,0), snake at (1..4,1).
        fmodel = '0;
        set_cell(0, 0, 3'd5);
        for (int x = 1; x <= 4; x++) set_cell(x, 1, 3'd2);
        run_frame(0, 0, 0);
        check_eq("a_beats", beats, 100);
        check_eq("a_data", mism, 0);
        check_eq("a_done", {done_seen, fd_ok}, 2'b11);
        check_eq("a_early_done", early_fd, 0);
        check_eq("a_beat1", {rec_code[0], rec_rgb[0], rec_sof[0]}, {3'd5, 12'hF00, 1'b1});
        for (int i = 11; i <= 14; i++)
            check_eq($sformatf("a_beat%0d", i + 1), {rec_code[i], rec_rgb[i]}, {3'd2, 12'h0F0});
        check_eq("a_beat100", {rec_x[99], rec_y[99], rec_eof[99]}, {4'd9, 4'd9, 1'b1});
        check_eq("a_snake_len", st_len, STATS ? 4 : 0);
        check_eq("a_apple", {st_av, st_ax, st_ay}, STATS ? 9'h100 : 9'h000);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("a_done_pulse", {frame_done, busy}, 0);
        check_eq("a_stats_hold", {snake_len, apple_valid}, STATS ? {7'd4, 1'b1} : 8'd0);

        // Frame B: same field with stalls.
        run_frame(1, 0, 0);
        check_eq("b_beats", beats, 100);
        check_eq("b_data", mism, 0);
        check_eq("b_stall_stable", stall_err, 0);
        check_eq("b_done", {done_seen, fd_ok}, 2'b11);

        // Frame C: field cleared right after the request.
        run_frame(0, 1, 0);
        check_eq("c_beats", beats, 100);
        check_eq("c_snapshot", mism, 0);
        check_eq("c_beat1_apple", rec_code[0], 3'd5);

        // Reset after beat 37.
        @(posedge clk); #1;
        field = fmodel; frame_req = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 37 && cyc < 200) begin
            @(negedge clk);
            if (out_valid && out_ready) cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("r_beats_before", cnt, 37);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("r_valid_off", {out_valid, busy}, 0);
        vcnt = 0; fcnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
            if (frame_done) fcnt++;
        end
        check_eq("r_no_beats", vcnt, 0);
        check_eq("r_no_done", fcnt, 0);
        check_eq("r_stats", {snake_len, apple_valid, apple_x, apple_y}, 0);

        // Reset wins over a simultaneous request.
        @(posedge clk); #1;
        frame_req = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; frame_req = 1'b0;
        @(negedge clk);
        check_eq("r_over_req", {busy, out_valid}, 0);

        // Request held high through a whole frame.
        run_frame(0, 0, 1);
        check_eq("h_beats", beats, 100);
        check_eq("h_done", {done_seen, fd_ok}, 2'b11);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("h_idle_gap", {busy, out_valid}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("h_restart", {out_valid, out_sof}, 2'b11);
        frame_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame D: illegal codes, no apple, mixed snake codes.
        fmodel = '0;
        set_cell(0, 0, 3'd1);
        set_cell(1, 0, 3'd3);
        set_cell(2, 0, 3'd4);
        set_cell(3, 0, 3'd6);
        set_cell(9, 9, 3'd7);
        run_frame(0, 0, 0);
        check_eq("d_beats", beats, 100);
        check_eq("d_data", mism, 0);
        check_eq("d_beat100", {rec_code[99], rec_err[99], rec_rgb[99]}, {3'd7, 1'b1, 12'hF0F});
        check_eq("d_beat4", {rec_err[3], rec_rgb[3]}, {1'b1, 12'hF0F});
        check_eq("d_snake_len", st_len, STATS ? 3 : 0);
        check_eq("d_no_apple", {st_av, st_ax, st_ay}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
